mdio_mgmt_arbiter: RTL and testbench

- Sequences and shares the MDIO master engine between a host register-access port and a built-in PHY status autopoller.
- Issues one management frame at a time over a start/done handshake and returns read data to the winning requester.
- Bounds each frame with a timeout and derives link status from polled BMSR.
- Sits between system control logic and the MDIO master engine.

---
 rtl/mdio_pkg.sv | 26 ++
 rtl/mdio_poll_timer.sv | 33 +++
 rtl/mdio_mgmt_arbiter.sv | 136 +++++++++++++
 tb/tb_mdio_mgmt_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO management arbiter: FSM states,
// requester identities and MDIO frame opcodes.
package mdio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        HOST = 1'b0,
        POLL = 1'b1
    } grant_t;

    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [4:0] BMSR_ADDR = 5'd1;
    localparam int         BMSR_LINK = 2;

    function automatic logic [1:0] op_for(input logic we);
        return we ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Autopoll interval timer: raises pending once every POLL_DIV enabled cycles
// and holds it until the arbiter retires the poll frame.
module mdio_poll_timer #(
    parameter logic [23:0] POLL_DIV = 24'd1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic poll_en,
    input  logic clear,
    output logic pending
);

    logic [23:0] count;
    logic        wrap;

    assign wrap = poll_en && (count == POLL_DIV - 24'd1);

    always_ff @(posedge CLK) begin
        if (RST || !poll_en) begin
            count   <= 24'd0;
            pending <= 1'b0;
        end else begin
            count <= wrap ? 24'd0 : count + 24'd1;
            // A fresh interval elapsing outranks retiring the previous poll.
            if (wrap) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdio_mgmt_arbiter.sv
// Shares one MDIO master engine between host register accesses and the
// PHY status autopoller, one frame at a time, with a per-frame timeout.
module mdio_mgmt_arbiter
    import mdio_pkg::*;
#(
    parameter logic [23:0] POLL_DIV    = 24'd1_000_000,
    parameter logic [4:0]  POLL_REG    = BMSR_ADDR,
    parameter int          LINK_BIT    = BMSR_LINK,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [4:0]  host_phy,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        host_err,
    input  logic        poll_en,
    input  logic [4:0]  poll_phy,
    output logic [15:0] status_reg,
    output logic        status_valid,
    output logic        link_up,
    output logic        link_change,
    output logic        mst_start,
    output logic        mst_we,
    output logic [4:0]  mst_phy,
    output logic [4:0]  mst_reg,
    output logic [15:0] mst_wdata,
    input  logic        mst_done,
    input  logic [15:0] mst_rdata
);

    state_t      state;
    grant_t      grant;
    grant_t      last_grant;
    logic [15:0] tcnt;
    logic        poll_pending;
    logic        poll_clear;
    logic        frame_end;

    assign poll_clear = (state == DONE) && (grant == POLL);
    assign frame_end  = mst_done || (tcnt == TIMEOUT_CYC - 16'd1);

    mdio_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll_timer (
        .CLK     (CLK),
        .RST     (RST),
        .poll_en (poll_en),
        .clear   (poll_clear),
        .pending (poll_pending)
    );

    // Frame results are registered on the WAIT->DONE edge so they are
    // visible for exactly the DONE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            grant        <= HOST;
            last_grant   <= HOST;
            tcnt         <= 16'd0;
            host_ack     <= 1'b0;
            host_rdata   <= 16'd0;
            host_err     <= 1'b0;
            status_reg   <= 16'd0;
            status_valid <= 1'b0;
            link_up      <= 1'b0;
            link_change  <= 1'b0;
            mst_start    <= 1'b0;
            mst_we       <= 1'b0;
            mst_phy      <= 5'd0;
            mst_reg      <= 5'd0;
            mst_wdata    <= 16'd0;
        end else begin
            mst_start   <= 1'b0;
            host_ack    <= 1'b0;
            link_change <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req || poll_pending) begin
                        if (host_req && (!poll_pending || last_grant == POLL)) begin
                            grant     <= HOST;
                            mst_we    <= (op_for(host_we) == OP_WRITE);
                            mst_phy   <= host_phy;
                            mst_reg   <= host_reg;
                            mst_wdata <= host_wdata;
                        end else begin
                            grant     <= POLL;
                            mst_we    <= (op_for(1'b0) == OP_WRITE);
                            mst_phy   <= poll_phy;
                            mst_reg   <= POLL_REG;
                            mst_wdata <= 16'd0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mst_start <= 1'b1;
                    tcnt      <= 16'd0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (frame_end) begin
                        if (grant == HOST) begin
                            host_ack   <= 1'b1;
                            host_err   <= !mst_done;
                            host_rdata <= !mst_done ? 16'hFFFF :
                                          (mst_we ? 16'h0000 : mst_rdata);
                        end else if (mst_done) begin
                            status_reg   <= mst_rdata;
                            status_valid <= 1'b1;
                            link_up      <= mst_rdata[LINK_BIT];
                            link_change  <= (mst_rdata[LINK_BIT] != link_up);
                        end else begin
                            status_valid <= 1'b0;
                        end
                        last_grant <= grant;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_mgmt_arbiter.sv
// Bench for mdio_mgmt_arbiter: host vector table, randomized host frames against
// an arithmetic model, autopoll link tracking, contention and reset corners.
module tb_mdio_mgmt_arbiter;

    localparam int          TMO      = 64;
    localparam logic [4:0]  POLL_PHY = 5'd7;

    logic        CLK;
    logic        RST;
    logic        host_req;
    logic        host_we;
    logic [4:0]  host_phy;
    logic [4:0]  host_reg;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        host_err;
    logic        poll_en;
    logic [4:0]  poll_phy;
    logic [15:0] status_reg;
    logic        status_valid;
    logic        link_up;
    logic        link_change;
    logic        mst_start;
    logic        mst_we;
    logic [4:0]  mst_phy;
    logic [4:0]  mst_reg;
    logic [15:0] mst_wdata;
    logic        mst_done;
    logic [15:0] mst_rdata;

    int n_vec = 0;
    int n_err = 0;

    mdio_mgmt_arbiter #(
        .POLL_DIV    (24'd50),
        .TIMEOUT_CYC (16'd64)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_phy     (host_phy),
        .host_reg     (host_reg),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .host_err     (host_err),
        .poll_en      (poll_en),
        .poll_phy     (poll_phy),
        .status_reg   (status_reg),
        .status_valid (status_valid),
        .link_up      (link_up),
        .link_change  (link_change),
        .mst_start    (mst_start),
        .mst_we       (mst_we),
        .mst_phy      (mst_phy),
        .mst_reg      (mst_reg),
        .mst_wdata    (mst_wdata),
        .mst_done     (mst_done),
        .mst_rdata    (mst_rdata)
    );

    // Clock and watchdog.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    // Engine model: answers each mst_start after eng_delay cycles unless muted.
    logic [15:0] rd_q[$];
    int          eng_delay = 0;
    bit          eng_mute  = 0;
    bit          eng_busy  = 0;
    int          eng_cnt   = 0;
    logic [15:0] eng_data  = 16'd0;
    int          link_pulses = 0;

    initial begin
        mst_done  = 1'b0;
        mst_rdata = 16'd0;
    end

    always @(negedge CLK) begin
        mst_done = 1'b0;
        if (link_change) link_pulses++;
        if (RST) begin
            eng_busy = 0;
        end else begin
            if (mst_start) begin
                eng_busy = !eng_mute;
                eng_cnt  = eng_delay;
                eng_data = (rd_q.size() != 0) ? rd_q.pop_front() : 16'($urandom);
            end
            if (eng_busy) begin
                if (eng_cnt == 0) begin
                    mst_done  = 1'b1;
                    mst_rdata = eng_data;
                    eng_busy  = 0;
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic [15:0] eng_rdata;
        int          delay;
        bit          mute;
        bit          drop;
        logic [15:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } host_vec_t;

    // One host frame: checks request->start latency, frame fields, their
    // stability, start->ack latency, returned data/error and the ack width.
    task automatic host_xact(input host_vec_t v, input string tag);
        int cyc;
        bit seen;
        bit unstable;
        rd_q.delete();
        rd_q.push_back(v.eng_rdata);
        eng_delay  = v.delay;
        eng_mute   = v.mute;
        host_we    = v.we;
        host_phy   = v.phy;
        host_reg   = v.regad;
        host_wdata = v.wdata;
        host_req   = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 8) begin
            cyc++;
            @(negedge CLK);
            if (mst_start) seen = 1;
        end
        chk({tag, " start_lat"}, seen ? cyc : 0, 2);
        chk({tag, " fields"}, {mst_we, mst_phy, mst_reg, mst_wdata},
            {v.we, v.phy, v.regad, v.wdata});
        if (v.drop) host_req = 1'b0;
        cyc = 0;
        seen = 0;
        unstable = 0;
        while (!seen && cyc < 100) begin
            cyc++;
            @(negedge CLK);
            if (host_ack) seen = 1;
            if ({mst_we, mst_phy, mst_reg, mst_wdata} !== {v.we, v.phy, v.regad, v.wdata})
                unstable = 1;
        end
        chk({tag, " ack_lat"}, seen ? cyc : 0, v.exp_lat);
        chk({tag, " rdata_err"}, {host_rdata, host_err}, {v.exp_rdata, v.exp_err});
        chk({tag, " fields_held"}, unstable, 0);
        host_req = 1'b0;
        @(negedge CLK);
        chk({tag, " ack_width"}, host_ack, 0);
    endtask

    task automatic wait_start(input string tag);
        int cyc;
        cyc = 0;
        while (!mst_start && cyc < 200) begin
            cyc++;
            @(negedge CLK);
        end
        if (!mst_start) chk({tag, " start_seen"}, 0, 1);
    endtask

    typedef struct {
        logic [15:0] data;
        bit          mute;
        logic [15:0] exp_status;
        bit          exp_valid;
        bit          exp_link;
        bit          exp_change;
    } poll_vec_t;

    host_vec_t vecs[9];
    poll_vec_t pvecs[4];

    initial begin
        host_vec_t v;
        int lat;

        // Expected values: latency = delay+1 unless that passes the 64-cycle
        // timeout, in which case 64 and FFFF/err.
        vecs[0] = '{0, 5'd1, 5'd0, 16'h0000, 16'h1140, 50, 0, 0, 16'h1140, 0, 51};
        vecs[1] = '{1, 5'd1, 5'd0, 16'h0FFA, 16'hBEEF, 20, 0, 0, 16'h0000, 0, 21};
        vecs[2] = '{0, 5'd1, 5'd4, 16'h0000, 16'h2222, 0,  1, 0, 16'hFFFF, 1, 64};
        vecs[3] = '{0, 5'd3, 5'd2, 16'h0000, 16'h0141, 5,  0, 0, 16'h0141, 0, 6};
        vecs[4] = '{0, 5'd3, 5'd2, 16'h0000, 16'hA5A5, 63, 0, 0, 16'hA5A5, 0, 64};
        vecs[5] = '{0, 5'd3, 5'd2, 16'h0000, 16'hA5A5, 64, 0, 0, 16'hFFFF, 1, 64};
        vecs[6] = '{1, 5'd9, 5'd0, 16'h1234, 16'h3333, 0,  1, 0, 16'hFFFF, 1, 64};
        vecs[7] = '{0, 5'd1, 5'd1, 16'h0000, 16'h0001, 0,  0, 0, 16'h0001, 0, 1};
        vecs[8] = '{0, 5'd2, 5'd5, 16'h0000, 16'h5A5A, 10, 0, 1, 16'h5A5A, 0, 11};

        pvecs[0] = '{16'h7809, 0, 16'h7809, 1, 0, 0};
        pvecs[1] = '{16'h780D, 0, 16'h780D, 1, 1, 1};
        pvecs[2] = '{16'h780D, 0, 16'h780D, 1, 1, 0};
        pvecs[3] = '{16'h0000, 1, 16'h780D, 0, 1, 0};

        RST        = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_phy   = 5'd0;
        host_reg   = 5'd0;
        host_wdata = 16'd0;
        poll_en    = 1'b0;
        poll_phy   = POLL_PHY;
        repeat (3) @(negedge CLK);
        chk("reset data", {host_rdata, status_reg, mst_wdata}, 0);
        chk("reset flags", {host_ack, host_err, status_valid, link_up, link_change,
                            mst_start, mst_we, mst_phy, mst_reg}, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Host vector table, autopoll off.
        for (int i = 0; i < 9; i++) begin
            host_xact(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge CLK);
        end
        chk("no poll side effects", {status_valid, status_reg}, 0);

        // Randomized host frames against the timeout/data arithmetic model.
        for (int i = 0; i < 24; i++) begin
            v.we        = 1'($urandom_range(0, 1));
            v.phy       = 5'($urandom);
            v.regad     = 5'($urandom);
            v.wdata     = 16'($urandom);
            v.eng_rdata = 16'($urandom);
            v.delay     = $urandom_range(0, 70);
            v.mute      = ($urandom_range(0, 7) == 0);
            v.drop      = 1'($urandom_range(0, 1));
            v.exp_err   = v.mute || (v.delay + 1 > TMO);
            v.exp_lat   = v.exp_err ? TMO : v.delay + 1;
            v.exp_rdata = v.exp_err ? 16'hFFFF : (v.we ? 16'h0000 : v.eng_rdata);
            host_xact(v, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // Autopoll link tracking, including a timed-out poll.
        link_pulses = 0;
        eng_delay   = 5;
        poll_en     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_q.delete();
            rd_q.push_back(pvecs[i].data);
            eng_mute = pvecs[i].mute;
            @(negedge CLK);
            wait_start($sformatf("poll%0d", i));
            chk($sformatf("poll%0d frame", i), {mst_we, mst_phy, mst_reg},
                {1'b0, POLL_PHY, 5'd1});
            lat = pvecs[i].mute ? TMO : eng_delay + 1;
            repeat (lat) @(negedge CLK);
            chk($sformatf("poll%0d status", i),
                {status_reg, status_valid, link_up, link_change},
                {pvecs[i].exp_status, pvecs[i].exp_valid, pvecs[i].exp_link,
                 pvecs[i].exp_change});
        end
        @(negedge CLK);
        chk("link_change pulses", link_pulses, 1);
        poll_en  = 1'b0;
        eng_mute = 0;
        repeat (4) @(negedge CLK);

        // Contention: long frames guarantee a pending poll at every arbitration.
        rd_q.delete();
        eng_delay  = 60;
        host_we    = 1'b0;
        host_phy   = 5'd1;
        host_reg   = 5'd0;
        host_wdata = 16'd0;
        host_req   = 1'b1;
        poll_en    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            wait_start($sformatf("rr%0d", i));
            chk($sformatf("rr%0d grant", i), {mst_we, mst_phy, mst_reg},
                (i % 2 == 1) ? {1'b0, POLL_PHY, 5'd1} : {1'b0, 5'd1, 5'd0});
        end
        host_req = 1'b0;
        poll_en  = 1'b0;
        repeat (80) @(negedge CLK);

        // Reset in the middle of a frame: silent abort, then a fresh frame.
        eng_mute   = 1;
        host_phy   = 5'd2;
        host_reg   = 5'd3;
        host_req   = 1'b1;
        repeat (20) @(negedge CLK);
        RST      = 1'b1;
        host_req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk("midreset data", {host_rdata, status_reg, mst_wdata}, 0);
        chk("midreset flags", {host_ack, host_err, status_valid, link_up, link_change,
                               mst_start, mst_we, mst_phy, mst_reg}, 0);
        lat = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (host_ack) lat++;
        end
        chk("midreset no ack", lat, 0);
        host_xact(vecs[0], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
